serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial unsigned adder that computes `a + b` one bit per clock, LSB first. It uses a registered carry between bit positions, and each bit slice is the full-add built from two half-add stages plus an OR on the carries. It sits downstream of the combinational half-adder stage and wraps it in a start/busy/done handshake. Callers trade latency for a single-bit datapath.

## Interface

Parameters:
- `WIDTH`, default 8: operand and sum width in bits. Legal values are 2 to 32.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to begin an addition. Sampled only in IDLE.
- `a`  input  WIDTH  operand A. Captured on the accepting edge.
- `b`  input  WIDTH  operand B. Captured on the accepting edge.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle pulse; `sum` and `carry_out` are valid while it is high.
- `sum`  output  WIDTH  result register.
- `carry_out`  output  1  carry out of bit WIDTH-1.

Clocking and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).

## Operation

- State machine states: IDLE, SHIFT, DONE.
- IDLE:
  - If `start`=1 at the clock edge: load shift registers A←`a` and B←`b`, clear the internal carry to 0, clear the bit counter to 0, go to SHIFT.
  - `sum` and `carry_out` are not modified on this edge.
- SHIFT, on each edge:
  - s = A[0] ^ B[0] ^ c and c' = (A[0]&B[0]) | ((A[0]^B[0])&c). This is two half-add stages with the two carries ORed.
  - Shift A and B right by one.
  - Shift s into the result shift register at the MSB; the register shifts right.
  - c ← c', counter ← counter+1.
  - When counter == WIDTH-1 on that edge, the final bit is processed and the state goes to DONE.
- Result registers:
  - `sum` is the result shift register itself, so it shows partial values during SHIFT.
  - `carry_out` is loaded with c' on the final SHIFT edge only.
- DONE: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` in SHIFT or DONE is ignored; there is no queuing.
- Changes to `a`/`b` after the accepting edge have no effect.
- Arithmetic is unsigned modulo 2^WIDTH; overflow is reported only via `carry_out`.
- Counter width is clog2(WIDTH) bits, and the counter never wraps within an operation.
- `sum` and `carry_out` hold their values after DONE until the next accepted `start` begins shifting.

## Timing

- Reset (async assert, any state):
  - State returns to IDLE.
  - `busy`=0, `done`=0, `sum`=0, `carry_out`=0.
  - Internal A, B, carry and counter are all cleared to 0.
- Reset mid-operation aborts the addition; no `done` is produced.
- Deassertion of `rst_n` is synchronous to `clk` at system level; the block needs no special handling for it.
- Call the accepting edge E0:
  - `busy`=1 after E0.
  - SHIFT edges are E1..E_WIDTH.
  - `done`=1 in the cycle after E_WIDTH.
  - `busy`=0 and `done`=0 after E_(WIDTH+1).
- Latency from the accepting edge to `done` high is WIDTH+1 edges.
- Throughput is one addition per WIDTH+2 cycles when `start` is held high continuously. The next accepting edge is E_(WIDTH+2), the first edge in IDLE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset values: assert `rst_n`=0 → `busy`=0, `done`=0, `sum`=0x00, `carry_out`=0 immediately, without waiting for a clock.
- Exact latency (WIDTH=8): `a`=0xA5, `b`=0x5A, one-cycle `start` → `done` high exactly 9 edges after the accepting edge, `sum`=0xFF, `carry_out`=0, `busy` high for 9 cycles.
- Full ripple overflow: `a`=0xFF, `b`=0x01 → `sum`=0x00, `carry_out`=1. Then `a`=0x80, `b`=0x80 → `sum`=0x00, `carry_out`=1.
- Start ignored while busy:
  - Start `a`=0x03, `b`=0x04.
  - Pulse `start` with `a`=0xFF, `b`=0xFF at E3.
  - Required: `sum`=0x07, `carry_out`=0, and only one `done` pulse.
- Reset mid-operation: assert `rst_n` low during SHIFT (E4) → outputs 0 at once and no `done`. After release, `a`=0x10, `b`=0x20 → `sum`=0x30.
- Back-to-back with `start` held high: `a`=0x7F, `b`=0x01 → `sum`=0x80, `carry_out`=0. Second acceptance occurs at E10, and `sum` holds 0x80 until E11.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-add per clock, LSB first, with a registered
// carry between bit positions and a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       w_ha0;
  logic [1:0]       w_ha1;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  always_comb begin
    w_ha0  = half_add(r_a[0], r_b[0]);
    w_ha1  = half_add(w_ha0[0], r_c);
    w_s    = w_ha1[0];
    w_c    = w_ha0[1] | w_ha1[1];
    w_last = (r_cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The counter stops at the last bit so it never wraps inside one addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sum  <= '0;
      r_c    <= 1'b0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        SHIFT: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_sum <= {w_s, r_sum[WIDTH-1:1]};
          r_c   <= w_c;
          if (w_last) r_cout <= w_c;
          else        r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: table of operand/result records plus hand-built
// sequences for busy-time start, mid-operation reset and back-to-back starts.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
  } vec_t;

  vec_t       tbl [10];
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_done  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      n_done++;
      check("pending_before_done", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("result", {23'd0, carry_out, sum}, {23'd0, mon_e});
      end
    end
  end

  task automatic do_add(input logic [7:0] ta, input logic [7:0] tb2, input logic [8:0] e);
    int k;
    int bc;
    bit got;
    @(negedge clk);
    a = ta; b = tb2; start = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    a = ~ta; b = ~tb2;
    k = 0; bc = 0; got = 1'b0;
    while (!got && k < 30) begin
      @(negedge clk);
      k++;
      if (busy) bc++;
      if (done) got = 1'b1;
    end
    check("done_seen", 32'(got), 1);
    check("latency", k, 9);
    check("busy_cycles", bc, 9);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd0;
    logic [7:0] ra, rb;

    tbl[0] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    tbl[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    tbl[6] = '{8'h55, 8'hAA, 8'hFF, 1'b0};
    tbl[7] = '{8'h3C, 8'hC3, 8'hFF, 1'b0};
    tbl[8] = '{8'h12, 8'h34, 8'h46, 1'b0};
    tbl[9] = '{8'h99, 8'h99, 8'h32, 1'b1};

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(carry_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", {22'd0, busy, done, sum}, 0);

    for (int i = 0; i < 10; i++)
      do_add(tbl[i].a, tbl[i].b, {tbl[i].c, tbl[i].s});

    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_add(ra, rb, {1'b0, ra} + {1'b0, rb});
    end

    // Start pulsed while busy is ignored.
    nd0 = n_done;
    @(negedge clk);
    a = 8'h03; b = 8'h04; start = 1'b1;
    exp_q.push_back(9'h007);
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    check("single_done", n_done - nd0, 1);
    check("queue_drained_ignore", exp_q.size(), 0);

    // Reset in the middle of shifting aborts the addition.
    @(negedge clk);
    a = 8'hA5; b = 8'h5A; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(busy), 1);
    check("pre_reset_sum", 32'(sum), 32'hF0);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {22'd0, busy, done, carry_out, sum}, 0);
    nd0 = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("no_done_after_abort", n_done - nd0, 0);
    do_add(8'h10, 8'h20, 9'h030);

    // Start held high: second acceptance at E10, sum holds until E11.
    @(negedge clk);
    a = 8'h7F; b = 8'h01; start = 1'b1;
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h002);
    @(posedge clk);
    #1 a = 8'h01; b = 8'h01;
    repeat (9) @(posedge clk);
    #1;
    check("b2b_idle_e9", {30'd0, busy, done}, 0);
    check("b2b_sum_e9", {23'd0, carry_out, sum}, 32'h080);
    @(posedge clk);
    #1;
    check("b2b_busy_e10", 32'(busy), 1);
    check("b2b_sum_e10", 32'(sum), 32'h80);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("b2b_sum_e11", 32'(sum), 32'h40);
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    check("queue_drained_b2b", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
